// File: rtl/seg_disp_sched_pkg.sv
// seg_disp_sched_pkg: shared constants, FSM states and BCD helper for the display scheduler
package seg_disp_sched_pkg;
  localparam logic RST_ENABLE = 1'b0;
  localparam int BCD_DIGITS = 6;
  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int DISP_DW = 20;
  localparam logic [DISP_DW-1:0] MAX_DISP = 20'd999_999;
  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_SHOW} state_t;
  function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] v);
    for (int i = 0; i < BCD_DIGITS; i++)
      v[4*i +: 4] = v[4*i +: 4] >= 4'd5 ? v[4*i +: 4] + 4'd3 : v[4*i +: 4];
    return v;
  endfunction
endpackage

// File: rtl/seg_bin2bcd.sv
// seg_bin2bcd: iterative double-dabble, one shift per cycle, done pulses after the 20th shift
module seg_bin2bcd
  import seg_disp_sched_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [DISP_DW-1:0] din,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   bcd
);
  logic [DISP_DW-1:0] bin;
  logic [4:0] cnt;
  logic [BCD_W-1:0] adj;
  assign adj = dabble(bcd);
  // the load also performs the first shift: adding 3 never applies to an all-zero accumulator
  always_ff @(posedge clk)
    if (resetn == RST_ENABLE) begin
      busy <= 1'b0;
      done <= 1'b0;
      bcd <= '0;
      bin <= '0;
      cnt <= '0;
    end else if (start) begin
      bcd <= BCD_W'(din[DISP_DW-1]);
      bin <= din << 1;
      cnt <= 5'(DISP_DW - 1);
      busy <= 1'b1;
      done <= 1'b0;
    end else begin
      done <= busy && cnt == 5'd1;
      if (busy) begin
        bcd <= (adj << 1) | BCD_W'(bin[DISP_DW-1]);
        bin <= bin << 1;
        cnt <= cnt - 5'd1;
        busy <= cnt != 5'd1;
      end
    end
endmodule

// File: rtl/seg_disp_sched.sv
// seg_disp_sched: round-robin sharing of the 6-digit display, with BCD conversion and dwell timing
module seg_disp_sched
  import seg_disp_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = DISP_DW,
  parameter int DWELL = 50_000_000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    grant,
  output logic [BCD_W-1:0]   bcd,
  output logic               bcd_valid,
  output logic               bcd_upd,
  output logic               ovf,
  output logic               busy
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(DWELL + 1);
  state_t state;
  logic [PW-1:0] ptr, win, nxt;
  logic found;
  logic [DW-1:0] snap;
  logic [CW-1:0] cnt;
  logic conv_start, conv_busy, conv_done, clamp;
  logic [BCD_W-1:0] conv_bcd;
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = 0; k < NREQ; k++)
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        win = PW'((int'(ptr) + k) % NREQ);
      end
  end
  assign nxt = PW'((int'(win) + 1) % NREQ);
  assign clamp = snap > MAX_DISP;
  assign conv_start = state == ST_CONV && !conv_busy && !conv_done;
  seg_bin2bcd u_conv (
    .clk(clk),
    .resetn(resetn),
    .start(conv_start),
    .din(clamp ? MAX_DISP : snap),
    .busy(conv_busy),
    .done(conv_done),
    .bcd(conv_bcd)
  );
  always_ff @(posedge clk)
    if (resetn == RST_ENABLE) begin
      state <= ST_IDLE;
      ptr <= '0;
      snap <= '0;
      cnt <= '0;
      grant <= '0;
      bcd <= '0;
      bcd_valid <= 1'b0;
      bcd_upd <= 1'b0;
      ovf <= 1'b0;
      busy <= 1'b0;
    end else begin
      bcd_upd <= 1'b0;
      case (state)
        ST_IDLE:
          if (found) begin
            grant <= NREQ'(1) << win;
            snap <= req_data[win*DW +: DW];
            ptr <= nxt;
            busy <= 1'b1;
            state <= ST_CONV;
          end
        ST_CONV:
          if (conv_done) begin
            bcd <= conv_bcd;
            bcd_upd <= 1'b1;
            bcd_valid <= 1'b1;
            ovf <= clamp;
            cnt <= '0;
            state <= ST_SHOW;
          end
        default:
          if (!(|(req & grant)) || cnt == CW'(DWELL - 1)) begin
            grant <= '0;
            busy <= 1'b0;
            state <= ST_IDLE;
          end else cnt <= cnt + 1'b1;
      endcase
    end
endmodule

// File: tb/tb_seg_disp_sched.sv
// tb_seg_disp_sched: scoreboard-based scenario tests for the display scheduler
module tb_seg_disp_sched;
  localparam int NREQ = 4, DW = 20, DWELL = 8;
  logic clk = 1'b0, resetn = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0] grant;
  logic [23:0] bcd;
  logic bcd_valid, bcd_upd, ovf, busy;
  typedef struct {logic [23:0] bcd; logic ovf; logic [NREQ-1:0] grant;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;

  seg_disp_sched #(.NREQ(NREQ), .DW(DW), .DWELL(DWELL)) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_data(req_data), .grant(grant),
    .bcd(bcd), .bcd_valid(bcd_valid), .bcd_upd(bcd_upd), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(int v);
    logic [23:0] r;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  always @(negedge clk)
    if (resetn && bcd_upd) begin
      exp_t e;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: unexpected update bcd=%h grant=%b, required no update", bcd, grant);
      end else begin
        e = sb.pop_front();
        if ({bcd, ovf, grant, bcd_valid} !== {e.bcd, e.ovf, e.grant, 1'b1}) begin
          n_fail++;
          $display("FAIL scoreboard: bcd=%h ovf=%b grant=%b valid=%b, required bcd=%h ovf=%b grant=%b valid=1",
                   bcd, ovf, grant, bcd_valid, e.bcd, e.ovf, e.grant);
        end
      end
    end

  always @(negedge clk)
    if (resetn) begin
      logic bad;
      bad = !$onehot0(grant) || (busy !== (grant != '0));
      for (int i = 0; i < 6; i++) if (bcd[4*i +: 4] > 4'd9) bad = 1'b1;
      n_chk++;
      if (bad) begin
        n_fail++;
        $display("FAIL invariant: grant=%b busy=%b bcd=%h, required one-hot-or-zero grant, busy==(grant!=0), digits<=9",
                 grant, busy, bcd);
      end
    end

  // what: 0 = grant set, 1 = bcd_upd pulse, 2 = grant clear; c = negedges waited, -1 on timeout
  task automatic wait_for(input int what, output int c);
    c = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if ((what == 0 && grant != '0) || (what == 1 && bcd_upd) || (what == 2 && grant == '0)) begin
        c = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({grant, bcd, bcd_valid, bcd_upd, ovf, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: grant=%b bcd=%h valid=%b upd=%b ovf=%b busy=%b, required all zero",
               grant, bcd, bcd_valid, bcd_upd, ovf, busy);
    end
    resetn = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({grant, bcd, bcd_valid, bcd_upd, ovf, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: grant=%b bcd=%h valid=%b busy=%b, required all zero", grant, bcd, bcd_valid, busy);
    end
  endtask

  task automatic test_single;
    int c;
    req_data[19:0] = 20'd123456;
    sb.push_back('{24'h123456, 1'b0, 4'b0001});
    req = 4'b0001;
    wait_for(0, c);
    n_chk++;
    if (grant !== 4'b0001 || c !== 1) begin
      n_fail++;
      $display("FAIL single_grant: grant=%b after %0d cycles, required 0001 after 1", grant, c);
    end
    n_chk++;
    if (bcd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_valid_early: bcd_valid=%b, required 0", bcd_valid);
    end
    wait_for(1, c);
    n_chk++;
    if (c !== 21) begin
      n_fail++;
      $display("FAIL single_latency: %0d cycles, required 21", c);
    end
    req = '0;
    wait_for(2, c);
    n_chk++;
    if (c !== 1) begin
      n_fail++;
      $display("FAIL single_release: idle after %0d cycles, required 1", c);
    end
    n_chk++;
    if (bcd !== 24'h123456 || bcd_valid !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL single_hold: bcd=%h valid=%b ovf=%b, required 123456 1 0", bcd, bcd_valid, ovf);
    end
  endtask

  task automatic test_saturate;
    int c;
    req_data[19:0] = 20'hFFFFF;
    sb.push_back('{24'h999999, 1'b1, 4'b0001});
    req = 4'b0001;
    wait_for(0, c);
    repeat (3) @(negedge clk);
    req_data[19:0] = 20'd5;
    wait_for(1, c);
    n_chk++;
    if (ovf !== 1'b1 || c < 0) begin
      n_fail++;
      $display("FAIL sat_ovf: ovf=%b wait=%0d, required ovf=1", ovf, c);
    end
    req_data[19:0] = 20'd0;
    sb.push_back('{24'h000000, 1'b0, 4'b0001});
    wait_for(1, c);
    n_chk++;
    if (c !== DWELL + 22) begin
      n_fail++;
      $display("FAIL sat_refresh: refresh period %0d, required %0d", c, DWELL + 22);
    end
    n_chk++;
    if (ovf !== 1'b0 || bcd !== 24'h0) begin
      n_fail++;
      $display("FAIL sat_zero: bcd=%h ovf=%b, required 000000 0", bcd, ovf);
    end
    req = '0;
    wait_for(2, c);
  endtask

  task automatic test_round_robin;
    int c;
    logic [NREQ-1:0] eg;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*DW +: DW] = 20'(111111 * (i + 1));
      sb.push_back('{to_bcd(111111 * (i + 1)), 1'b0, 4'b0001 << i});
    end
    sb.push_back('{to_bcd(111111), 1'b0, 4'b0001});
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      eg = 4'b0001 << (t % 4);
      wait_for(0, c);
      n_chk++;
      if (grant !== eg) begin
        n_fail++;
        $display("FAIL rr_grant%0d: grant=%b, required %b", t, grant, eg);
      end
      wait_for(1, c);
      if (t == 4) req = '0;
      wait_for(2, c);
      n_chk++;
      if (c !== (t < 4 ? DWELL : 1)) begin
        n_fail++;
        $display("FAIL rr_show%0d: show lasted %0d cycles, required %0d", t, c, t < 4 ? DWELL : 1);
      end
    end
  endtask

  task automatic test_back_to_back;
    int c;
    sb.push_back('{to_bcd(333333), 1'b0, 4'b0100});
    sb.push_back('{to_bcd(111111), 1'b0, 4'b0001});
    req = 4'b0101;
    wait_for(0, c);
    n_chk++;
    if (grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL skip_grant: grant=%b, required 0100", grant);
    end
    wait_for(1, c);
    repeat (2) @(negedge clk);
    req = 4'b0001;
    wait_for(2, c);
    n_chk++;
    if (c !== 1) begin
      n_fail++;
      $display("FAIL skip_release: idle after %0d cycles, required 1", c);
    end
    wait_for(0, c);
    n_chk++;
    if (grant !== 4'b0001 || c !== 1) begin
      n_fail++;
      $display("FAIL skip_next: grant=%b after %0d cycles, required 0001 after 1", grant, c);
    end
    wait_for(1, c);
    req = '0;
    wait_for(2, c);
    n_chk++;
    if (bcd !== to_bcd(111111)) begin
      n_fail++;
      $display("FAIL skip_hold: bcd=%h, required 111111", bcd);
    end
  endtask

  task automatic test_reset_mid_conv;
    int c;
    req_data[19:0] = 20'd654321;
    sb.push_back('{24'h654321, 1'b0, 4'b0001});
    req = 4'b0001;
    wait_for(0, c);
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({grant, bcd, bcd_valid, bcd_upd, ovf, busy} !== '0) begin
      n_fail++;
      $display("FAIL midconv_reset: grant=%b bcd=%h valid=%b ovf=%b busy=%b, required all zero",
               grant, bcd, bcd_valid, ovf, busy);
    end
    sb.delete();
    sb.push_back('{24'h654321, 1'b0, 4'b0001});
    resetn = 1'b1;
    wait_for(0, c);
    wait_for(1, c);
    n_chk++;
    if (c !== 21) begin
      n_fail++;
      $display("FAIL midconv_restart: latency %0d, required 21", c);
    end
    req = '0;
    wait_for(2, c);
  endtask

  task automatic test_idle;
    resetn = 1'b0;
    req = '0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_chk++;
      if ({grant, bcd, bcd_valid, bcd_upd, ovf, busy} !== '0) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: grant=%b bcd=%h valid=%b busy=%b, required all zero",
                 i, grant, bcd, bcd_valid, busy);
      end
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d updates outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturate();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_conv();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
